// File: rtl/dct_pkg.sv
// Shared types and helpers for the streaming 4-point integer DCT.
// The saturation helper is only referenced when DCT_CLIP_EN is defined.
package dct_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  typedef enum logic {
    DCT_FWD = 1'b0,
    DCT_INV = 1'b1
  } mode_t;

  localparam int N_PTS = 4;

  // Clamp a value into the signed range of a dw-bit word
  function automatic logic signed [31:0] sat_fn(input logic signed [31:0] v, input int dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    if (v > hi) begin
      sat_fn = hi;
    end else if (v < lo) begin
      sat_fn = lo;
    end else begin
      sat_fn = v;
    end
  endfunction

endpackage

// File: rtl/dct4_core.sv
// Combinational 4-point forward/inverse integer butterfly.
// With DCT_CLIP_EN defined, inverse results saturate to the input sample range.
module dct4_core
  import dct_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = DATA_W + 3
) (
  input  logic signed [DATA_W-1:0] x_i [N_PTS],
  input  mode_t                    mode_i,
  output logic signed [OUT_W-1:0]  y_o [N_PTS]
);

  logic signed [OUT_W-1:0] xe_s [N_PTS];
  logic signed [OUT_W-1:0] s0_s, s1_s, d0_s, d1_s;
  logic signed [OUT_W-1:0] e0_s, e1_s, e2_s, e3_s;

`ifdef DCT_CLIP_EN
  function automatic logic signed [OUT_W-1:0] clip_f(input logic signed [OUT_W-1:0] v);
    clip_f = OUT_W'(sat_fn(32'(v), DATA_W));
  endfunction
`endif

  // Butterfly stages for both directions, then select by mode
  always_comb begin
    for (int i = 0; i < N_PTS; i++) begin
      xe_s[i] = OUT_W'(x_i[i]);
    end
    s0_s = xe_s[0] + xe_s[3];
    s1_s = xe_s[1] + xe_s[2];
    d0_s = xe_s[0] - xe_s[3];
    d1_s = xe_s[1] - xe_s[2];
    e0_s = xe_s[0] + xe_s[2];
    e1_s = xe_s[0] - xe_s[2];
    e2_s = (xe_s[1] >>> 1'b1) - xe_s[3];
    e3_s = xe_s[1] + (xe_s[3] >>> 1'b1);
    case (mode_i)
      DCT_FWD: begin
        y_o[0] = s0_s + s1_s;
        y_o[1] = (d0_s <<< 1'b1) + d1_s;
        y_o[2] = s0_s - s1_s;
        y_o[3] = d0_s - (d1_s <<< 1'b1);
      end
      DCT_INV: begin
`ifdef DCT_CLIP_EN
        y_o[0] = clip_f(e0_s + e3_s);
        y_o[1] = clip_f(e1_s + e2_s);
        y_o[2] = clip_f(e1_s - e2_s);
        y_o[3] = clip_f(e0_s - e3_s);
`else
        y_o[0] = e0_s + e3_s;
        y_o[1] = e1_s + e2_s;
        y_o[2] = e1_s - e2_s;
        y_o[3] = e0_s - e3_s;
`endif
      end
      default: begin
        for (int i = 0; i < N_PTS; i++) begin
          y_o[i] = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/dct4_stream.sv
// Handshaked 4-point DCT: collect 4 samples, compute for one cycle, emit 4 results.
// Optional DCT_CLIP_EN saturates inverse results (see dct4_core).
module dct4_stream
  import dct_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = DATA_W + 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] dt_i,
  input  logic                     mode_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [OUT_W-1:0]  dt_o,
  output logic [1:0]               out_idx_o,
  output logic                     out_last_o,
  output logic [CNT_W-1:0]         blk_cnt_o
);

  state_t                  state_r, state_nxt_s;
  logic [1:0]              in_idx_r;
  logic signed [DATA_W-1:0] x_r [N_PTS];
  mode_t                   mode_r;
  logic signed [OUT_W-1:0] y_s [N_PTS];
  logic signed [OUT_W-1:0] y_r [N_PTS];
  logic                    in_ready_r, out_valid_r, last_r;
  logic signed [OUT_W-1:0] dt_r;
  logic [1:0]              out_idx_r;
  logic [CNT_W-1:0]        blk_cnt_r;
  logic                    in_hs_s, out_hs_s;

  assign in_hs_s  = in_valid_i && in_ready_r;
  assign out_hs_s = out_ready_i && out_valid_r;

  dct4_core #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_core (
    .x_i    (x_r),
    .mode_i (mode_r),
    .y_o    (y_s)
  );

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COLLECT: begin
        if (in_hs_s && (in_idx_r == 2'd3)) begin
          state_nxt_s = COMPUTE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      COMPUTE: state_nxt_s = EMIT;
      EMIT: begin
        if (out_hs_s && (out_idx_r == 2'd3)) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = COLLECT;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sample buffer, result registers and registered stream outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_PTS; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
      in_idx_r    <= 2'd0;
      mode_r      <= DCT_FWD;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      dt_r        <= '0;
      out_idx_r   <= 2'd0;
      last_r      <= 1'b0;
      blk_cnt_r   <= '0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (in_hs_s) begin
            x_r[in_idx_r] <= dt_i;
            in_idx_r      <= in_idx_r + 2'd1;
            if (in_idx_r == 2'd0) begin
              mode_r <= mode_t'(mode_i);
            end
            if (in_idx_r == 2'd3) begin
              in_ready_r <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          y_r         <= y_s;
          dt_r        <= y_s[0];
          out_idx_r   <= 2'd0;
          last_r      <= 1'b0;
          out_valid_r <= 1'b1;
        end
        EMIT: begin
          if (out_hs_s) begin
            if (out_idx_r == 2'd3) begin
              out_valid_r <= 1'b0;
              in_ready_r  <= 1'b1;
              last_r      <= 1'b0;
              out_idx_r   <= 2'd0;
              dt_r        <= '0;
              blk_cnt_r   <= blk_cnt_r + CNT_W'(1'b1);
            end else begin
              out_idx_r <= out_idx_r + 2'd1;
              dt_r      <= y_r[out_idx_r + 2'd1];
              last_r    <= (out_idx_r == 2'd2);
            end
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign dt_o        = dt_r;
  assign out_idx_o   = out_idx_r;
  assign out_last_o  = last_r;
  assign blk_cnt_o   = blk_cnt_r;

endmodule

// File: tb/tb_dct4_stream.sv
// Directed and randomized checks of dct4_stream against a matrix-form reference model.
module tb_dct4_stream;

  localparam int DATA_W = 8;
  localparam int OUT_W  = DATA_W + 3;
  localparam int CNT_W  = 16;

  typedef int blk_t [4];

  localparam int FWD_M [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
  // inverse rows act on {x0, x1, x2, x3, floor(x1/2), floor(x3/2)}
  localparam int INV_M [4][6] = '{'{1, 1, 1, 0, 0, 1}, '{1, 0, -1, -1, 1, 0},
                                  '{1, 0, -1, 1, -1, 0}, '{1, -1, 1, 0, 0, -1}};

  logic                     clk = 1'b0;
  logic                     rst, in_valid, in_ready, mode, out_valid, out_ready, out_last;
  logic signed [DATA_W-1:0] dt_in;
  logic signed [OUT_W-1:0]  dt_out;
  logic [1:0]               out_idx;
  logic [CNT_W-1:0]         blk_cnt;

  int checks = 0;
  int errors = 0;
  int blocks = 0;

  always #5 clk = ~clk;

  dct4_stream #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .dt_i        (dt_in),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .dt_o        (dt_out),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .blk_cnt_o   (blk_cnt)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int half_floor(input int v);
    if (v < 0) return -((-v + 1) / 2);
    else return v / 2;
  endfunction

  function automatic blk_t model(input blk_t x, input bit inv);
    blk_t y;
    int   v [6];
    int   lo, hi;
    v = '{x[0], x[1], x[2], x[3], half_floor(x[1]), half_floor(x[3])};
    lo = -(2 ** (DATA_W - 1));
    hi = (2 ** (DATA_W - 1)) - 1;
    for (int r = 0; r < 4; r++) begin
      y[r] = 0;
      if (!inv) begin
        for (int c = 0; c < 4; c++) y[r] += FWD_M[r][c] * x[c];
      end else begin
        for (int c = 0; c < 6; c++) y[r] += INV_M[r][c] * v[c];
`ifdef DCT_CLIP_EN
        if (y[r] > hi) y[r] = hi;
        if (y[r] < lo) y[r] = lo;
`endif
      end
    end
    return y;
  endfunction

  // Caller is at a falling edge; leaves at the falling edge after the last handshake.
  task automatic send_block(input blk_t x, input bit m, input bit toggle);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      dt_in    = DATA_W'(x[i]);
      mode     = (i == 0) ? m : (m ^ toggle ^ i[0]);
      chk("in_ready_collect", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("valid_in_compute", out_valid, 0);
    chk("ready_in_compute", in_ready, 0);
  endtask

  // First result must be valid exactly one cycle after send_block returns.
  task automatic recv_block(input blk_t exp, input int stall_i, input int stall_n);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_i) begin
        for (int c = 0; c < stall_n; c++) begin
          out_ready = 1'b0;
          in_valid  = 1'b1;
          dt_in     = DATA_W'($urandom);
          @(posedge clk);
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", dt_out, exp[i]);
          chk("stall_idx", out_idx, i);
          chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      chk("out_valid", out_valid, 1);
      chk("out_data", dt_out, exp[i]);
      chk("out_idx", out_idx, i);
      chk("out_last", out_last, (i == 3) ? 1 : 0);
      chk("in_ready_emit", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    blocks++;
    chk("idle_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("blk_cnt", blk_cnt, blocks);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dt", dt_out, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk_t x, e;
    bit   inv;
    int   si, sn;

    rst = 1'b1; in_valid = 1'b0; dt_in = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);

    send_block('{5, 10, 20, 0}, 1'b0, 1'b0);
    recv_block('{35, 0, -25, 25}, -1, 0);

    send_block('{39, 83, 80, 6}, 1'b0, 1'b0);
    recv_block('{208, 69, -118, 27}, -1, 0);

    send_block('{64, 0, 0, 0}, 1'b1, 1'b0);
    recv_block('{64, 64, 64, 64}, -1, 0);

    send_block('{-128, -128, -128, -128}, 1'b0, 1'b0);
    recv_block('{-512, 0, 0, 0}, -1, 0);

    send_block('{127, 127, 0, 0}, 1'b1, 1'b0);
`ifdef DCT_CLIP_EN
    recv_block('{127, 127, 64, 0}, -1, 0);
`else
    recv_block('{254, 190, 64, 0}, -1, 0);
`endif

    send_block('{1, 2, 3, 4}, 1'b0, 1'b0);
    recv_block('{10, -7, 0, -1}, 1, 3);

    // partial block then reset
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      dt_in    = DATA_W'(i + 50);
      mode     = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();
    blocks = 0;
    send_block('{5, 10, 20, 0}, 1'b0, 1'b1);
    recv_block('{35, 0, -25, 25}, -1, 0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) x[i] = int'($urandom_range(0, 255)) - 128;
      inv = 1'($urandom_range(0, 1));
      si  = int'($urandom_range(0, 4)) - 1;
      sn  = int'($urandom_range(1, 3));
      e   = model(x, inv);
      send_block(x, inv, 1'($urandom_range(0, 1)));
      recv_block(e, si, sn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
